shift_engine: RTL and testbench
===============================

SHIFT_ENGINE -- requirements
Module: shift_engine

Interface
REQ-001 Parameter W, default 8: register width in bits; W >= 2.
REQ-002 Parameter CW, default 4: width of the shift-amount port; maximum shift count per operation is 2^CW-1.
REQ-003 clk  input  1  clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset: synchronous, active-high.
REQ-005 load  input  1  parallel load request, honoured only in IDLE.
REQ-006 parallel_in  input  W  data written by load.
REQ-007 start  input  1  begin a multi-step shift operation, honoured only in IDLE.
REQ-008 mode  input  3  operation select, sampled with start.
REQ-009 amount  input  CW  number of single-bit steps, sampled with start.
REQ-010 serial_in  input  1  fill bit for SRL/SLL, sampled on every shift step.
REQ-011 parallel_out  output  W  current register contents.
REQ-012 msb_out  output  1  parallel_out[W-1].
REQ-013 lsb_out  output  1  parallel_out[0].
REQ-014 busy  output  1  high while in SHIFT state.
REQ-015 done  output  1  one-cycle pulse when an operation completes.

Function
REQ-016 Two-state FSM, states IDLE and SHIFT, shall be used.
REQ-017 In IDLE with load=1, the register shall take parallel_in at the next edge; no busy, no done.
REQ-018 In IDLE with load=0 and start=1, the block shall latch mode and amount at the same edge.
REQ-019 If the latched amount is 0, the block shall stay in IDLE, leave the register unchanged, and assert done for the cycle after the start edge.
REQ-020 If the latched amount is nonzero, the block shall enter SHIFT, with busy=1 from the start edge onward.
REQ-021 In SHIFT, exactly one single-bit step shall be applied per cycle, and the remaining count shall decrement per step.
REQ-022 For start sampled at edge T with amount N>0, steps shall occur at edges T+1..T+N.
REQ-023 At edge T+N, busy shall fall and done shall be 1 for exactly one cycle.
REQ-024 Mode 000 HOLD: each step leaves the register unchanged, but steps are still counted.
REQ-025 Mode 001 SRL: reg <= {serial_in, reg[W-1:1]}.
REQ-026 Mode 010 SLL: reg <= {reg[W-2:0], serial_in}.
REQ-027 Mode 011 ROR: reg <= {reg[0], reg[W-1:1]}.
REQ-028 Mode 100 ROL: reg <= {reg[W-2:0], reg[W-1]}.
REQ-029 Mode 101 ASR: reg <= {reg[W-1], reg[W-1:1]}.
REQ-030 Modes 110 and 111 shall behave as HOLD.
REQ-031 When load and start are both 1 in IDLE, load shall win and start shall be dropped; no operation begins.
REQ-032 While busy, load, start, mode and amount shall be ignored; the latched mode and amount shall govern the whole operation.
REQ-033 Back-to-back: start may be asserted in the cycle done=1 (FSM is in IDLE) and shall be accepted.
REQ-034 amount = 2^CW-1 exceeding W shall be legal; rotates wrap repeatedly, shifts saturate to fill bits.
REQ-035 msb_out and lsb_out shall be combinational taps of the register.

Reset
REQ-036 When rst=1 at an edge, the register shall be set to 0, the FSM to IDLE, the count to 0, busy to 0 and done to 0.
REQ-037 rst shall take priority over load, start and any in-progress operation, including mid-SHIFT abort with no done pulse.

Verification (W=8, CW=4)
REQ-038 Reset: assert rst -> parallel_out=0x00, busy=0, done=0; apply rst mid-operation -> same values next cycle, no done.
REQ-039 Load 0xA5, then start ROR amount 3 -> busy high for 3 cycles, parallel_out=0xB4, single done pulse; ROL 3 then returns 0xA5.
REQ-040 Load 0x90, then ASR amount 2 -> 0xE4; load 0x0F, then SLL amount 4 with serial_in=1 -> 0xFF; load 0xF0, then SRL amount 4 with serial_in=0 -> 0x0F.
REQ-041 load=1 and start=1 together with parallel_in=0x3C -> 0x3C, busy stays 0; start with amount 0 -> done the next cycle, value unchanged.
REQ-042 Pulse start and load during busy -> both ignored, final value per original op; start on the done cycle -> new op begins; ROR amount 15 on 0x01 -> 0x02.

Source files
------------

// File: rtl/shift_engine.sv
// rtl/shift_engine.sv - multi-step shift/rotate register with IDLE/SHIFT control FSM
module shift_engine #(
  parameter int W  = 8,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [W-1:0]  parallel_in,
  input  logic          start,
  input  logic [2:0]    mode,
  input  logic [CW-1:0] amount,
  input  logic          serial_in,
  output logic [W-1:0]  parallel_out,
  output logic          msb_out,
  output logic          lsb_out,
  output logic          busy,
  output logic          done
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  reg_q, reg_d;
  logic [2:0]    mode_q, mode_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;
  logic [W-1:0]  step;

  // One single-bit step of the latched operation; unused codes hold.
  always_comb begin
    step = reg_q;
    case (mode_q)
      3'b001:  step = {serial_in, reg_q[W-1:1]};
      3'b010:  step = {reg_q[W-2:0], serial_in};
      3'b011:  step = {reg_q[0], reg_q[W-1:1]};
      3'b100:  step = {reg_q[W-2:0], reg_q[W-1]};
      3'b101:  step = {reg_q[W-1], reg_q[W-1:1]};
      default: step = reg_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    reg_d   = reg_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Load wins over start when both are requested together.
        if (load) begin
          reg_d = parallel_in;
        end else if (start) begin
          mode_d = mode;
          cnt_d  = amount;
          if (amount == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = S_SHIFT;
          end
        end
      end
      S_SHIFT: begin
        reg_d = step;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      reg_q   <= '0;
      mode_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      reg_q   <= reg_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign parallel_out = reg_q;
  assign msb_out      = reg_q[W-1];
  assign lsb_out      = reg_q[0];
  assign busy         = (state_q == S_SHIFT);
  assign done         = done_q;

endmodule

// File: tb/tb_shift_engine.sv
// tb/tb_shift_engine.sv - directed and randomized checks of shift_engine against a closed-form model
module tb_shift_engine;

  logic       clk = 1'b0;
  logic       rst;
  logic       load;
  logic [7:0] parallel_in;
  logic       start;
  logic [2:0] mode;
  logic [3:0] amount;
  logic       serial_in;
  logic [7:0] parallel_out;
  logic       msb_out;
  logic       lsb_out;
  logic       busy;
  logic       done;

  int total = 0;
  int bad   = 0;
  logic [7:0] v_exp;

  shift_engine #(.W(8), .CW(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .load         (load),
    .parallel_in  (parallel_in),
    .start        (start),
    .mode         (mode),
    .amount       (amount),
    .serial_in    (serial_in),
    .parallel_out (parallel_out),
    .msb_out      (msb_out),
    .lsb_out      (lsb_out),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Whole-operation result computed directly from the count, not step by step.
  function automatic logic [7:0] ref_op(input logic [7:0] v, input logic [2:0] m,
                                        input int n, input logic s);
    logic [7:0]        fill;
    logic [15:0]       dd;
    logic signed [7:0] sv;
    int                r;
    logic [7:0]        res;
    fill = s ? 8'hFF : 8'h00;
    r    = n % 8;
    sv   = v;
    case (m)
      3'b001: res = (n >= 8) ? fill : ((v >> n) | (fill << (8 - n)));
      3'b010: res = (n >= 8) ? fill : ((v << n) | (fill >> (8 - n)));
      3'b011: begin dd = {v, v} >> r; res = dd[7:0];  end
      3'b100: begin dd = {v, v} << r; res = dd[15:8]; end
      3'b101: res = sv >>> n;
      default: res = v;
    endcase
    return res;
  endfunction

  task automatic do_load(input logic [7:0] d, input logic with_start);
    load = 1'b1; start = with_start; parallel_in = d;
    mode = 3'b011; amount = 4'd5;
    tick();
    load = 1'b0; start = 1'b0;
    v_exp = d;
    chk("load_value", parallel_out, v_exp);
    chk("load_busy", busy, 1'b0);
    chk("load_done", done, 1'b0);
    tick();
    chk("load_idle", busy, 1'b0);
  endtask

  // Returns with done sampled high when b2b is set, otherwise one cycle later.
  task automatic do_op(input logic [2:0] m, input logic [3:0] a, input logic s,
                       input logic disturb, input logic b2b);
    int n;
    start = 1'b1; mode = m; amount = a; serial_in = s;
    tick();
    start = 1'b0;
    chk("op_busy_rise", busy, (a != 0) ? 1'b1 : 1'b0);
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      chk("op_no_early_done", done, 1'b0);
      if (disturb && n == 0) begin
        load = 1'b1; start = 1'b1; parallel_in = $urandom;
        mode = $urandom; amount = $urandom;
      end
      tick();
      load = 1'b0; start = 1'b0;
      n++;
    end
    v_exp = ref_op(v_exp, m, int'(a), s);
    chk("op_busy_cycles", n, int'(a));
    chk("op_done_pulse", done, 1'b1);
    chk("op_value", parallel_out, v_exp);
    chk("op_msb", msb_out, v_exp[7]);
    chk("op_lsb", lsb_out, v_exp[0]);
    if (!b2b) begin
      tick();
      chk("op_done_fall", done, 1'b0);
      chk("op_value_hold", parallel_out, v_exp);
    end
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; start = 1'b0; parallel_in = '0;
    mode = '0; amount = '0; serial_in = 1'b0;
    tick();
    tick();
    chk("reset_value", parallel_out, 8'h00);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    rst = 1'b0;
    v_exp = 8'h00;
    tick();

    do_load(8'hA5, 1'b0);
    do_op(3'b011, 4'd3, 1'b0, 1'b0, 1'b0);
    chk("ror3_a5", parallel_out, 8'hB4);
    do_op(3'b100, 4'd3, 1'b0, 1'b0, 1'b0);
    chk("rol3_back", parallel_out, 8'hA5);

    do_load(8'h90, 1'b0);
    do_op(3'b101, 4'd2, 1'b0, 1'b0, 1'b0);
    chk("asr2_90", parallel_out, 8'hE4);
    do_load(8'h0F, 1'b0);
    do_op(3'b010, 4'd4, 1'b1, 1'b0, 1'b0);
    chk("sll4_fill1", parallel_out, 8'hFF);
    do_load(8'hF0, 1'b0);
    do_op(3'b001, 4'd4, 1'b0, 1'b0, 1'b0);
    chk("srl4_fill0", parallel_out, 8'h0F);

    do_load(8'h3C, 1'b1);
    chk("load_beats_start", parallel_out, 8'h3C);
    do_op(3'b011, 4'd0, 1'b0, 1'b0, 1'b0);
    chk("amount0_unchanged", parallel_out, 8'h3C);

    do_load(8'h5A, 1'b0);
    do_op(3'b100, 4'd5, 1'b0, 1'b1, 1'b1);
    do_op(3'b011, 4'd2, 1'b0, 1'b0, 1'b0);
    do_load(8'h01, 1'b0);
    do_op(3'b011, 4'd15, 1'b0, 1'b0, 1'b0);
    chk("ror15_01", parallel_out, 8'h02);
    do_op(3'b110, 4'd3, 1'b1, 1'b0, 1'b0);
    do_op(3'b000, 4'd2, 1'b1, 1'b0, 1'b0);

    start = 1'b1; mode = 3'b011; amount = 4'd6;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_value", parallel_out, 8'h00);
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    tick();
    chk("abort_no_done", done, 1'b0);
    chk("abort_stays_idle", busy, 1'b0);
    v_exp = 8'h00;

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        do_load(8'($urandom), 1'($urandom));
      end else begin
        do_op(3'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      end
    end
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
